circuit_checker: RTL

Self-checking stimulus sequencer for the four-input `circuit` gate-level block. It drives all 16 input combinations onto `a,b,c,d` and samples the block's `f` output after a programmable settle time. It compares each sample against the golden function `f = (c|d) & ~(a&b)`, then reports pass/fail, a mismatch count and the first failing vector. It sits beside the gate-level block as its on-chip driver and checker.

---
 rtl/circuit_checker.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/circuit_checker.sv
`default_nettype none
// ============================================================================
// Module      : circuit_checker
// Description : Self-checking stimulus sequencer for the four-input
//               `circuit` gate-level block. Sweeps {a,b,c,d} through all
//               16 combinations, waits SETTLE cycles per vector, samples f
//               and compares it against f = (c|d) & ~(a&b). Reports pass,
//               a saturating mismatch count and the first failing vector.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   SETTLE   : idle cycles between driving a vector and sampling f (0..15)
//   ERRW     : width of the mismatch counter (>= 1)
// Ports
//   clk      : in  - rising-edge clock
//   rst_n    : in  - asynchronous active-low reset
//   start    : in  - sweep request (taken in IDLE, or held through DONE)
//   f        : in  - output of the block under check
//   a,b,c,d  : out - registered stimulus, {a,b,c,d} = current vector
//   busy     : out - sweep in progress (DRIVE/WAIT/SAMPLE)
//   done     : out - one-cycle pulse when a sweep ends
//   pass     : out - last sweep had no mismatches
//   err_cnt  : out - saturating mismatch count of the last/current sweep
//   fail_vec : out - first mismatching vector (meaningful when pass = 0)
// Build option
//   CIRCUIT_CHK_STOP_ON_FAIL_EN : when defined, the first mismatch ends the
//                                 sweep immediately.
// ============================================================================
module circuit_checker #(
    parameter int SETTLE = 2,
    parameter int ERRW   = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            f,
    output logic            a,
    output logic            b,
    output logic            c,
    output logic            d,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [ERRW-1:0] err_cnt,
    output logic [3:0]      fail_vec
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Wait-counter preload; WAIT lasts (preload + 1) cycles. SETTLE = 0 skips
    // WAIT entirely, so its preload value is irrelevant there.
    localparam logic [3:0]      c_WAIT_LOAD = 4'((SETTLE == 0) ? 0 : SETTLE - 1);
    localparam logic [ERRW-1:0] c_ERR_MAX   = {ERRW{1'b1}};
    localparam logic [3:0]      c_LAST_VEC  = 4'hF;

`ifdef CIRCUIT_CHK_STOP_ON_FAIL_EN
    localparam bit c_STOP_ON_FAIL = 1'b1;
`else
    localparam bit c_STOP_ON_FAIL = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t          state_q,    state_d;
    logic [3:0]      vec_q,      vec_d;
    logic [3:0]      wait_q,     wait_d;
    logic [3:0]      stim_q,     stim_d;     // {a,b,c,d}
    logic            busy_q,     busy_d;
    logic            done_q,     done_d;
    logic            pass_q,     pass_d;
    logic [ERRW-1:0] err_cnt_q,  err_cnt_d;
    logic [3:0]      fail_vec_q, fail_vec_d;

    // ------------------------------------------------------------------------
    // Golden function, evaluated on the registered stimulus that the block
    // under check is actually seeing.
    // ------------------------------------------------------------------------
    logic exp_f;
    logic mismatch;
    logic last_vec;

    assign exp_f    = (stim_q[1] | stim_q[0]) & ~(stim_q[3] & stim_q[2]);
    assign mismatch = (f != exp_f);
    assign last_vec = (vec_q == c_LAST_VEC) || (c_STOP_ON_FAIL && mismatch);

    // ------------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        wait_d     = wait_q;
        stim_d     = stim_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        err_cnt_d  = err_cnt_q;
        fail_vec_d = fail_vec_q;

        case (state_q)
            ST_IDLE: begin
                stim_d = 4'h0;
                busy_d = 1'b0;
                if (start) begin
                    state_d    = ST_DRIVE;
                    vec_d      = 4'h0;
                    stim_d     = 4'h0;
                    busy_d     = 1'b1;
                    pass_d     = 1'b0;
                    err_cnt_d  = '0;
                    fail_vec_d = 4'h0;
                end
            end

            ST_DRIVE: begin
                wait_d  = c_WAIT_LOAD;
                state_d = (SETTLE == 0) ? ST_SAMPLE : ST_WAIT;
            end

            ST_WAIT: begin
                if (wait_q == 4'h0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    wait_d = wait_q - 4'h1;
                end
            end

            ST_SAMPLE: begin
                if (mismatch) begin
                    if (err_cnt_q != c_ERR_MAX) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                    // The counter saturates and never returns to zero
                    // mid-sweep, so zero identifies the first mismatch.
                    if (err_cnt_q == '0) begin
                        fail_vec_d = vec_q;
                    end
                end

                if (last_vec) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    stim_d  = 4'h0;
                    // Includes the result of this final sample.
                    pass_d  = (err_cnt_q == '0) && !mismatch;
                end else begin
                    state_d = ST_DRIVE;
                    vec_d   = vec_q + 4'h1;
                    stim_d  = vec_q + 4'h1;
                end
            end

            ST_DONE: begin
                // A start held high through DONE launches the next sweep on
                // the DONE exit edge, so back-to-back sweeps have no gap.
                if (start) begin
                    state_d    = ST_DRIVE;
                    vec_d      = 4'h0;
                    stim_d     = 4'h0;
                    busy_d     = 1'b1;
                    pass_d     = 1'b0;
                    err_cnt_d  = '0;
                    fail_vec_d = 4'h0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                stim_d  = 4'h0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            vec_q      <= 4'h0;
            wait_q     <= 4'h0;
            stim_q     <= 4'h0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_cnt_q  <= '0;
            fail_vec_q <= 4'h0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            wait_q     <= wait_d;
            stim_q     <= stim_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            err_cnt_q  <= err_cnt_d;
            fail_vec_q <= fail_vec_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign {a, b, c, d} = stim_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign err_cnt      = err_cnt_q;
    assign fail_vec     = fail_vec_q;

endmodule

`default_nettype wire
